// File: rtl/time_register_arbiter.sv
// Shared mm:ss BCD time register with a fixed-priority writer arbiter.
// Writers are clear, the 1 s tick, minutes adjust and seconds adjust. The
// block also owns the 1 s prescaler, the finish flag and the finish blink.
module time_register_arbiter #(
  parameter int TICK_DIV  = 50000000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       forward,
  input  logic       clr_req,
  input  logic       sec_req,
  input  logic       min_req,
  output logic [3:0] mDecimal,
  output logic [3:0] mUnit,
  output logic [3:0] sDecimal,
  output logic [3:0] sUnit,
  output logic [3:0] grant,
  output logic       tick,
  output logic       finish,
  output logic       blink
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic          clr_q, sec_q, min_q;
  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  logic          pend_tick, pend_min, pend_sec;
  logic          ev_clr, ev_tick, ev_min, ev_sec;
  logic          cand_clr, cand_tick, cand_min, cand_sec;
  logic          win_clr, win_tick, win_min, win_sec;
  logic [3:0]    m_t_nxt, m_u_nxt, s_t_nxt, s_u_nxt;
  logic          finish_nxt;
  logic          at_max, at_zero, at_one;

  assign ev_clr  = clr_req & ~clr_q;
  assign ev_sec  = sec_req & ~sec_q;
  assign ev_min  = min_req & ~min_q;
  assign ev_tick = run & (presc == PRESC_LAST);

  assign cand_clr  = ev_clr;
  assign cand_tick = ev_tick | pend_tick;
  assign cand_min  = ev_min | pend_min;
  assign cand_sec  = ev_sec | pend_sec;

  assign win_clr  = cand_clr;
  assign win_tick = cand_tick & ~cand_clr;
  assign win_min  = cand_min & ~cand_clr & ~cand_tick;
  assign win_sec  = cand_sec & ~cand_clr & ~cand_tick & ~cand_min;

  assign at_max  = (mDecimal == 4'd9) && (mUnit == 4'd9) && (sDecimal == 4'd5) && (sUnit == 4'd9);
  assign at_zero = (mDecimal == 4'd0) && (mUnit == 4'd0) && (sDecimal == 4'd0) && (sUnit == 4'd0);
  assign at_one  = (mDecimal == 4'd0) && (mUnit == 4'd0) && (sDecimal == 4'd0) && (sUnit == 4'd1);

  assign tick = grant[2];

  // Next time-register value and finish flag from the winning writer.
  always_comb begin
    m_t_nxt    = mDecimal;
    m_u_nxt    = mUnit;
    s_t_nxt    = sDecimal;
    s_u_nxt    = sUnit;
    finish_nxt = finish;
    if (win_clr) begin
      m_t_nxt    = 4'd0;
      m_u_nxt    = 4'd0;
      s_t_nxt    = 4'd0;
      s_u_nxt    = 4'd0;
      finish_nxt = 1'b0;
    end else if (win_tick) begin
      // Once finished, ticks are still granted but leave the value alone.
      if (!finish) begin
        if (forward) begin
          if (at_max) begin
            finish_nxt = 1'b1;
          end else if (sUnit != 4'd9) begin
            s_u_nxt = sUnit + 4'd1;
          end else begin
            s_u_nxt = 4'd0;
            if (sDecimal != 4'd5) begin
              s_t_nxt = sDecimal + 4'd1;
            end else begin
              s_t_nxt = 4'd0;
              if (mUnit != 4'd9) begin
                m_u_nxt = mUnit + 4'd1;
              end else begin
                m_u_nxt = 4'd0;
                m_t_nxt = mDecimal + 4'd1;
              end
            end
          end
        end else begin
          if (at_zero || at_one) finish_nxt = 1'b1;
          if (!at_zero) begin
            if (sUnit != 4'd0) begin
              s_u_nxt = sUnit - 4'd1;
            end else begin
              s_u_nxt = 4'd9;
              if (sDecimal != 4'd0) begin
                s_t_nxt = sDecimal - 4'd1;
              end else begin
                s_t_nxt = 4'd5;
                if (mUnit != 4'd0) begin
                  m_u_nxt = mUnit - 4'd1;
                end else begin
                  m_u_nxt = 4'd9;
                  m_t_nxt = mDecimal - 4'd1;
                end
              end
            end
          end
        end
      end
    end else if (win_min) begin
      finish_nxt = 1'b0;
      if (mUnit != 4'd9) begin
        m_u_nxt = mUnit + 4'd1;
      end else begin
        m_u_nxt = 4'd0;
        m_t_nxt = (mDecimal != 4'd9) ? mDecimal + 4'd1 : 4'd0;
      end
    end else if (win_sec) begin
      finish_nxt = 1'b0;
      if (sUnit != 4'd9) begin
        s_u_nxt = sUnit + 4'd1;
      end else begin
        s_u_nxt = 4'd0;
        s_t_nxt = (sDecimal != 4'd5) ? sDecimal + 4'd1 : 4'd0;
      end
    end
  end

  // Request edge detect, pending bookkeeping, prescaler and time register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // Load the live levels so a button held through reset is not an event.
      clr_q     <= clr_req;
      sec_q     <= sec_req;
      min_q     <= min_req;
      presc     <= '0;
      pend_tick <= 1'b0;
      pend_min  <= 1'b0;
      pend_sec  <= 1'b0;
      grant     <= 4'b0000;
      mDecimal  <= 4'd0;
      mUnit     <= 4'd0;
      sDecimal  <= 4'd0;
      sUnit     <= 4'd0;
      finish    <= 1'b0;
    end else begin
      clr_q     <= clr_req;
      sec_q     <= sec_req;
      min_q     <= min_req;
      if (win_clr || !run || presc == PRESC_LAST) presc <= '0;
      else                                         presc <= presc + PW'(1);
      // A serviced clear throws away everything else that was waiting.
      pend_tick <= cand_tick & ~win_tick & ~win_clr;
      pend_min  <= cand_min & ~win_min & ~win_clr;
      pend_sec  <= cand_sec & ~win_sec & ~win_clr;
      grant     <= {win_clr, win_tick, win_min, win_sec};
      mDecimal  <= m_t_nxt;
      mUnit     <= m_u_nxt;
      sDecimal  <= s_t_nxt;
      sUnit     <= s_u_nxt;
      finish    <= finish_nxt;
    end
  end

  // Blink phase: starts high as finish rises, then toggles each half-period.
  always_ff @(posedge clk) begin
    if (!reset) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (!finish_nxt) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (!finish) begin
      blink     <= 1'b1;
      blink_cnt <= BLINK_LAST;
    end else if (blink_cnt == '0) begin
      blink     <= ~blink;
      blink_cnt <= BLINK_LAST;
    end else begin
      blink_cnt <= blink_cnt - BW'(1);
    end
  end

endmodule

// File: tb/tb_time_register_arbiter.sv
// Scoreboard bench for time_register_arbiter (TICK_DIV=4, BLINK_DIV=3).
module tb_time_register_arbiter;

  logic       clk = 1'b0;
  logic       reset, run, forward, clr_req, sec_req, min_req;
  logic [3:0] mDecimal, mUnit, sDecimal, sUnit, grant;
  logic       tick, finish, blink;

  int n_checks = 0;
  int n_pass   = 0;
  int m_min    = 0;
  int m_sec    = 0;
  logic [20:0] exp_q[$];

  always #10 clk = ~clk;

  time_register_arbiter #(.TICK_DIV(4), .BLINK_DIV(3)) dut (
    .clk(clk), .reset(reset), .run(run), .forward(forward),
    .clr_req(clr_req), .sec_req(sec_req), .min_req(min_req),
    .mDecimal(mDecimal), .mUnit(mUnit), .sDecimal(sDecimal), .sUnit(sUnit),
    .grant(grant), .tick(tick), .finish(finish), .blink(blink)
  );

  function logic [15:0] digits();
    return {mDecimal, mUnit, sDecimal, sUnit};
  endfunction

  function automatic logic [15:0] bcd(int mm, int ss);
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expect_push(input logic [3:0] g, input int mm, input int ss, input logic fin);
    exp_q.push_back({g, bcd(mm, ss), fin});
    m_min = mm;
    m_sec = ss;
  endtask

  task automatic press_sec();
    @(posedge clk); #1 sec_req = 1'b1;
    expect_push(4'b0001, m_min, (m_sec + 1) % 60, 1'b0);
    @(posedge clk); #1 sec_req = 1'b0;
  endtask

  task automatic press_min();
    @(posedge clk); #1 min_req = 1'b1;
    expect_push(4'b0010, (m_min + 1) % 100, m_sec, 1'b0);
    @(posedge clk); #1 min_req = 1'b0;
  endtask

  task automatic press_clr();
    @(posedge clk); #1 clr_req = 1'b1;
    expect_push(4'b1000, 0, 0, 1'b0);
    @(posedge clk); #1 clr_req = 1'b0;
  endtask

  task automatic set_time(input int mm, input int ss);
    press_clr();
    repeat (mm) press_min();
    repeat (ss) press_sec();
  endtask

  // Monitor: every grant the DUT presents must match the next queued expectation.
  always @(negedge clk) begin
    logic [20:0] e;
    logic [20:0] act;
    if (reset === 1'b1 && grant !== 4'b0000) begin
      n_checks++;
      act = {grant, digits(), finish};
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_grant: got grant=%b time=%h fin=%b, expected no grant",
                 grant, digits(), finish);
      end else begin
        e = exp_q.pop_front();
        if (act === e) n_pass++;
        else $display("FAIL scoreboard: got grant=%b time=%h fin=%b, expected grant=%b time=%h fin=%b",
                      act[20:17], act[16:1], act[0], e[20:17], e[16:1], e[0]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; run = 1'b0; forward = 1'b1;
    clr_req = 1'b0; sec_req = 1'b0; min_req = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("reset_digits", digits(), 16'h0000);
    check("reset_grant", 16'(grant), 16'h0000);
    check("reset_flags", 16'({tick, finish, blink}), 16'h0000);
    reset = 1'b1;

    // Count up across the minute boundary.
    set_time(0, 58);
    forward = 1'b1;
    expect_push(4'b0100, 0, 59, 1'b0);
    expect_push(4'b0100, 1, 0, 1'b0);
    @(posedge clk); #1 run = 1'b1;
    repeat (3) @(posedge clk); #1 check("t1_no_early_tick", 16'(grant), 16'h0000);
    @(posedge clk); #1 check("t1_tick1", 16'({tick, grant}), 16'h0014);
    repeat (4) @(posedge clk); #1 check("t1_tick2", 16'({tick, grant}), 16'h0014);
    run = 1'b0;
    check("t1_time", digits(), 16'h0100);

    // Count down to zero, finish and blink.
    set_time(0, 1);
    forward = 1'b0;
    expect_push(4'b0100, 0, 0, 1'b1);
    expect_push(4'b0100, 0, 0, 1'b1);
    @(posedge clk); #1 run = 1'b1;
    repeat (4) @(posedge clk); #1 check("t2_finish_blink", 16'({finish, blink}), 16'h0003);
    repeat (2) @(posedge clk); #1 check("t2_blink_hold", 16'(blink), 16'h0001);
    @(posedge clk); #1 check("t2_blink_low", 16'(blink), 16'h0000);
    @(posedge clk); #1 run = 1'b0;
    repeat (2) @(posedge clk); #1 check("t2_blink_high", 16'(blink), 16'h0001);
    check("t2_time_hold", digits(), 16'h0000);
    press_sec();
    check("t2_finish_cleared", 16'({finish, blink}), 16'h0000);
    forward = 1'b1;

    // Tick and min on the same edge: tick first, min the cycle after.
    set_time(5, 30);
    expect_push(4'b0100, 5, 31, 1'b0);
    expect_push(4'b0010, 6, 31, 1'b0);
    @(posedge clk); #1 run = 1'b1;
    repeat (3) @(posedge clk); #1 min_req = 1'b1;
    @(posedge clk); #1 check("t3_tick_first", 16'(grant), 16'h0004);
    run = 1'b0;
    @(posedge clk); #1 check("t3_min_second", 16'(grant), 16'h0002);
    min_req = 1'b0;
    @(posedge clk); #1 check("t3_idle", 16'(grant), 16'h0000);

    // Seconds wrap without carry, 99:59 terminal, minutes wrap clears finish.
    set_time(12, 59);
    press_sec();
    check("t4_sec_no_carry", digits(), 16'h1200);
    repeat (87) press_min();
    repeat (59) press_sec();
    check("t4_at_max", digits(), 16'h9959);
    expect_push(4'b0100, 99, 59, 1'b1);
    @(posedge clk); #1 run = 1'b1;
    repeat (4) @(posedge clk); #1 run = 1'b0;
    check("t4_max_finish", 16'(finish), 16'h0001);
    press_min();
    check("t4_min_wrap", digits(), 16'h0059);
    check("t4_min_clears_finish", 16'({finish, blink}), 16'h0000);

    // Clear over pending min/sec; prescaler restarts a full period.
    set_time(34, 56);
    expect_push(4'b0100, 34, 57, 1'b0);
    expect_push(4'b1000, 0, 0, 1'b0);
    expect_push(4'b0100, 0, 1, 1'b0);
    @(posedge clk); #1 run = 1'b1;
    repeat (3) @(posedge clk); #1 begin min_req = 1'b1; sec_req = 1'b1; end
    @(posedge clk); #1 clr_req = 1'b1;
    check("t5_tick", 16'(grant), 16'h0004);
    @(posedge clk); #1 check("t5_clr", 16'(grant), 16'h0008);
    check("t5_clr_time", digits(), 16'h0000);
    @(posedge clk); #1 check("t5_pending_dropped", 16'(grant), 16'h0000);
    clr_req = 1'b0; min_req = 1'b0; sec_req = 1'b0;
    repeat (2) @(posedge clk); #1 check("t5_no_early_tick", 16'(grant), 16'h0000);
    @(posedge clk); #1 check("t5_tick_restart", 16'({tick, grant}), 16'h0014);
    run = 1'b0;

    // All four events together: only clear.
    expect_push(4'b1000, 0, 0, 1'b0);
    @(posedge clk); #1 run = 1'b1;
    repeat (3) @(posedge clk); #1 begin clr_req = 1'b1; min_req = 1'b1; sec_req = 1'b1; end
    @(posedge clk); #1 check("t5b_clr_only", 16'(grant), 16'h0008);
    run = 1'b0;
    @(posedge clk); #1 check("t5b_then_idle", 16'(grant), 16'h0000);
    clr_req = 1'b0; min_req = 1'b0; sec_req = 1'b0;
    @(posedge clk); #1 check("t5b_still_idle", 16'(grant), 16'h0000);

    // Button held through reset gives no event; a fresh press gives one.
    sec_req = 1'b1;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1 reset = 1'b1;
    m_min = 0; m_sec = 0;
    repeat (3) @(posedge clk); #1 check("t6_held_no_inc", digits(), 16'h0000);
    sec_req = 1'b0;
    @(posedge clk); #1 sec_req = 1'b1;
    expect_push(4'b0001, 0, 1, 1'b0);
    @(posedge clk); #1 sec_req = 1'b0;
    repeat (3) @(posedge clk); #1 check("t6_single_inc", digits(), 16'h0001);

    repeat (4) @(posedge clk); #1;
    check("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/time_register_arbiter.md
Name: time_register_arbiter

Overview:
Owns the shared mm:ss BCD time register of the timer and arbitrates every writer to it: the 1 s tick, the manual seconds and minutes adjust buttons, and clear. The run and direction controls come from the timer state machine. The debounced button levels come from the debouncer. The four BCD digits drive the VGA painter. The block also generates the 1 s prescaler tick, a finish flag and a finish-blink strobe for the display.

Parameters:
TICK_DIV, 50000000, clk cycles per 1 s tick; minimum 2.
BLINK_DIV, 25000000, clk cycles per blink half-period.

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-low reset
run  in  1  count enable from the state machine
forward  in  1  1 = count up, 0 = count down
clr_req  in  1  debounced delete level
sec_req  in  1  debounced seconds-increment level
min_req  in  1  debounced minutes-increment level
mDecimal  out  4  minutes tens, BCD 0-9
mUnit  out  4  minutes units, BCD 0-9
sDecimal  out  4  seconds tens, BCD 0-5
sUnit  out  4  seconds units, BCD 0-9
grant  out  4  one-hot {clr,tick,min,sec}; registered; high for 1 cycle per serviced request
tick  out  1  1-cycle pulse, same cycle as grant[2]
finish  out  1  count reached its terminal value
blink  out  1  display blink phase; 0 when finish=0

Behaviour:
- Reset (reset=0 at a clk edge): digits=0, grant=0, tick=0, finish=0, blink=0, prescaler=0, blink counter=0, all pending bits=0. Each req_q register loads its current req input, so a button held through reset produces no event.
- Events: each req is a level. Its event is req & ~req_q, sampled at the edge. req_q updates every edge.
- Prescaler: counts only while run=1. It wraps at TICK_DIV-1 and raises the tick event on that edge. It is held at 0 when run=0. It is cleared when clr is serviced.
- Pending: any event that is not serviced on its edge sets its pending bit. No event is ever lost. The pending bit clears when that request is serviced.
- Arbitration: at most one update per edge. Candidates are event OR pending. Fixed priority: clr > tick > min > sec. The winner updates the register on that edge. grant/tick show the winner during the next cycle.
- clr: all digits=0, finish=0. Discards pending tick, min and sec.
- tick, forward=1:
  - Seconds +1; 59 -> 00 with a carry into minutes +1.
  - At 99:59: value holds and finish=1.
- tick, forward=0:
  - Seconds -1; 00 -> 59 with a borrow from minutes.
  - A tick that yields 00:00 sets finish=1.
  - A tick at 00:00 holds the value and sets finish=1.
- tick while finish=1: granted, value unchanged.
- sec: seconds +1, 59 -> 00 with no carry into minutes. Clears finish.
- min: minutes +1, 99 -> 00. Clears finish.
- Digits always hold legal BCD. Seconds tens never exceed 5.
- blink:
  - Goes to 1 on the edge finish rises.
  - Toggles every BLINK_DIV cycles while finish=1.
  - Forced to 0, with its counter cleared, when finish=0.
- run falling mid-second: prescaler is cleared. An already pending tick is still serviced.
- Simultaneous clr, tick, min and sec events: clr granted, the others are discarded (clr rule). Next cycle grant=0.

Test Plan:
- TICK_DIV=4, run=1, forward=1 from 00:58 -> tick every 4 cycles; 00:59, then 01:00; grant=0100 with each tick.
- forward=0 from 00:01, run=1 -> next tick gives 00:00 and finish=1. blink=1 next cycle, toggling every BLINK_DIV=3 cycles. Further ticks are granted, value stays 00:00.
- min_req and tick event on the same edge at 05:30 (forward=1) -> grant=0100 (05:31), then next cycle grant=0010 (06:31).
- sec_req rising at 12:59 -> 12:00, no minute carry. min_req rising at 99:xx -> 00:xx. finish cleared if set.
- clr_req rising together with pending min and sec at 34:56 -> 00:00, grant=1000, then grant stays 0. Prescaler restarts a full 4 cycles to the next tick.
- sec_req held high through reset and after release of reset -> no increment. Then toggle low/high -> exactly one increment.
